matrix_mult_scheduler: RTL

Sequencer that computes C = A × B for square floating-point matrices by reusing one `column_processor` instance, one cell at a time. It latches both operand matrices on a start pulse and walks C in row-major order. For each cell it issues row i of A and column j of B to the processor, collects the scalar result and acknowledges it. The finished matrix is presented to the host with a ready/ack handshake. It sits between the coprocessor host interface and the `column_processor` datapath.

---
 rtl/matrix_mult_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/matrix_mult_scheduler.sv
// Row-major cell sequencer for C = A x B over one shared column_processor.
// Latches A and B on start, issues row i / column j per cell, collects results and hands C to the host.
module matrix_mult_scheduler #(
  parameter int size       = 4,
  parameter int cell_width = 32,
  parameter int width      = cell_width * size,
  parameter int mat_width  = width * size,
  parameter int timeout    = 1024
) (
  input  logic                 in_clk,
  input  logic                 in_reset,
  input  logic                 in_start,
  input  logic [mat_width-1:0] in_mat_a,
  input  logic [mat_width-1:0] in_mat_b,
  input  logic                 out_ack,
  output logic [mat_width-1:0] out_mat_c,
  output logic                 out_ready,
  output logic                 out_busy,
  output logic                 out_error,
  output logic [15:0]          out_cycles,
  output logic [width-1:0]     proc_row_a,
  output logic [width-1:0]     proc_col_b,
  output logic                 proc_ready,
  output logic                 proc_ack,
  input  logic                 proc_out_ready,
  input  logic [width-1:0]     proc_cell
);

  localparam int idx_w  = (size > 1) ? $clog2(size) : 1;
  localparam int wait_w = $clog2(timeout + 1);
  localparam logic [idx_w-1:0]  last_idx  = idx_w'(size - 1);
  localparam logic [wait_w-1:0] wait_last = wait_w'(timeout - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [mat_width-1:0] r_a;
  logic [mat_width-1:0] r_b;
  logic [mat_width-1:0] r_c;
  logic [idx_w-1:0]     r_i;
  logic [idx_w-1:0]     r_j;
  logic [wait_w-1:0]    r_wait;
  logic                 r_error;
  logic [15:0]          r_cycles;
  logic [width-1:0]     w_row_a;
  logic [width-1:0]     w_col_b;
  logic                 w_last_cell;
  logic                 w_wait_expired;

  assign w_last_cell    = (r_i == last_idx) && (r_j == last_idx);
  // The count reaches timeout on this edge, so the abort fires one cycle before r_wait would equal it.
  assign w_wait_expired = (r_wait == wait_last);

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // NOTE: every variable in an always_comb gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_start) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (proc_out_ready)      w_next = S_ACK;
        else if (w_wait_expired) w_next = S_DONE;
      end
      S_ACK:   w_next = w_last_cell ? S_DONE : S_ISSUE;
      S_DONE:  if (out_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: the matrix storage is reset like any other register so a mid-job reset leaves no stale C visible.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_wait   <= '0;
      r_error  <= 1'b0;
      r_cycles <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_start) begin
            r_a      <= in_mat_a;
            r_b      <= in_mat_b;
            r_c      <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_wait   <= '0;
            r_error  <= 1'b0;
            r_cycles <= '0;
          end
        end
        S_WAIT: begin
          if (proc_out_ready) begin
            r_c[(int'(r_i) * size + int'(r_j)) * cell_width +: cell_width] <= proc_cell[cell_width-1:0];
          end else begin
            r_wait <= r_wait + 1'b1;
            if (w_wait_expired) r_error <= 1'b1;
          end
        end
        S_ACK: begin
          r_wait <= '0;
          if (!w_last_cell) begin
            if (r_j == last_idx) begin
              r_j <= '0;
              r_i <= r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if ((r_state == S_ISSUE || r_state == S_WAIT || r_state == S_ACK) && (r_cycles != 16'hFFFF))
        r_cycles <= r_cycles + 16'd1;
    end
  end

  // Operands come straight from the latched matrices and indices, which only move on the S_ACK exit edge.
  always_comb begin
    w_row_a = '0;
    w_col_b = '0;
    for (int k = 0; k < size; k++) begin
      w_row_a[k*cell_width +: cell_width] = r_a[(int'(r_i) * size + k) * cell_width +: cell_width];
      w_col_b[k*cell_width +: cell_width] = r_b[(k * size + int'(r_j)) * cell_width +: cell_width];
    end
  end

  generate
    if (size > 1) begin : g_unused_cell
      logic w_unused_cell;
      assign w_unused_cell = ^proc_cell[width-1:cell_width];
    end
  endgenerate

  assign proc_row_a = w_row_a;
  assign proc_col_b = w_col_b;
  assign proc_ready = (r_state == S_ISSUE);
  assign proc_ack   = (r_state == S_ACK);
  assign out_ready  = (r_state == S_DONE);
  assign out_busy   = (r_state != S_IDLE);
  assign out_mat_c  = r_c;
  assign out_error  = r_error;
  assign out_cycles = r_cycles;

endmodule
